// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 scanning multiplexer.
//   state_e     : controller states (IDLE, MANUAL, SCAN)
//   MODE_*      : encoding of the mode input
//   DEF_NCH/W   : default channel count and channel data width
package mux_pkg;

    localparam int unsigned DEF_NCH = 16;
    localparam int unsigned DEF_W   = 8;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational channel selector: y = channel idx of the flattened input bus.
//   in  : NCH*W flattened channels, channel k at [k*W +: W]
//   idx : channel index
//   y   : selected channel data
module mux_sel_comb #(
    parameter int unsigned NCH = 16,
    parameter int unsigned W   = 8,
    localparam int unsigned SW = $clog2(NCH)
) (
    input  logic [NCH*W-1:0] in,
    input  logic [SW-1:0]    idx,
    output logic [W-1:0]     y
);

    // NCH is a power of two, so every idx value addresses a real channel.
    always_comb begin
        y = in[int'(idx)*W +: W];
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-to-1 multiplexer with manual selection or round-robin scanning, feeding a
// single registered valid/ready output stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in             : NCH*W flattened channel data
//   sel            : channel index used in manual mode
//   mode           : 0 manual, 1 scan; sampled when leaving IDLE
//   en             : enables captures; dropping it returns to IDLE
//   out_data/ch    : captured data and its channel index
//   out_last       : beat carries channel NCH-1 in scan mode
//   out_valid      : output register holds an unconsumed beat
//   out_ready      : downstream accepts the beat
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    parameter int unsigned W   = DEF_W,
    localparam int unsigned SW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in,
    input  logic [SW-1:0]    sel,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e        state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] ch_q, ch_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;

    logic [SW-1:0] idx_c;
    logic [W-1:0]  sel_data_c;
    logic          accept_c;
    logic          free_c;

    // Scan reads the pointer, manual reads the external select.
    assign idx_c = (state_q == SCAN) ? ptr_q : sel;

    mux_sel_comb #(
        .NCH (NCH),
        .W   (W)
    ) u_sel (
        .in  (in),
        .idx (idx_c),
        .y   (sel_data_c)
    );

    assign accept_c = valid_q & out_ready;
    assign free_c   = ~valid_q | out_ready;

    // Next-state, pointer and output-register update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        valid_d = valid_q;

        // A pending beat retires on handshake unless replaced by a capture.
        if (accept_c) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    if (mode == MODE_SCAN) begin
                        state_d = SCAN;
                        ptr_d   = '0;
                    end else begin
                        state_d = MANUAL;
                    end
                end
            end
            MANUAL, SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (free_c) begin
                    data_d  = sel_data_c;
                    ch_d    = idx_c;
                    valid_d = 1'b1;
                    if (state_q == SCAN) begin
                        last_d = (ptr_q == SW'(NCH - 1));
                        ptr_d  = ptr_q + SW'(1);
                    end else begin
                        last_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Testbench for mux_nto1_scan: a 16x8 instance checked against a
// transaction-level reference model, plus 2x1 and 64x32 instances for
// parameter corner cases.
module tb_mux_nto1_scan;

    logic clk;
    logic rst_n;

    // Main instance, NCH=16 W=8.
    logic [127:0] in_v;
    logic [3:0]   sel;
    logic         mode, en, out_ready;
    logic [7:0]   out_data;
    logic [3:0]   out_ch;
    logic         out_last, out_valid;

    // Small instance, NCH=2 W=1.
    logic [1:0]   in2;
    logic         en2, d2, ch2, last2, valid2;

    // Large instance, NCH=64 W=32.
    logic [2047:0] in64;
    logic          en64, last64, valid64;
    logic [31:0]   d64;
    logic [5:0]    ch64;

    int errors = 0;
    int asserts = 0;

    // Reference model: phase 0 idle, 1 manual, 2 scan; one pending beat.
    int         m_phase;
    int         m_ptr;
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    logic       m_last;

    mux_nto1_scan #(.NCH(16), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v), .sel(sel), .mode(mode), .en(en),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nto1_scan #(.NCH(2), .W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in(in2), .sel(1'b0), .mode(1'b1), .en(en2),
        .out_data(d2), .out_ch(ch2), .out_last(last2),
        .out_valid(valid2), .out_ready(1'b1)
    );

    mux_nto1_scan #(.NCH(64), .W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in(in64), .sel(6'd0), .mode(1'b1), .en(en64),
        .out_data(d64), .out_ch(ch64), .out_last(last64),
        .out_valid(valid64), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ch    = 0;
        m_last  = 1'b0;
    endtask

    // One clock edge of the behaviour: what the downstream sees next.
    task automatic model_step(input logic e, input logic md, input int s,
                              input logic r, input logic [127:0] iv);
        logic acc;
        int   c;
        acc = m_valid && r;
        if (m_phase == 0) begin
            if (e) begin
                m_phase = md ? 2 : 1;
                if (md) m_ptr = 0;
            end
            if (acc) m_valid = 1'b0;
        end else if (!e) begin
            m_phase = 0;
            if (acc) m_valid = 1'b0;
        end else if (!m_valid || r) begin
            c       = (m_phase == 2) ? m_ptr : s;
            m_data  = iv[c*8 +: 8];
            m_ch    = c;
            m_last  = (m_phase == 2) && (c == 15);
            m_valid = 1'b1;
            if (m_phase == 2) m_ptr = (m_ptr + 1) % 16;
        end
    endtask

    // Advance one cycle, then sample outputs 1 time unit after the edge.
    task automatic tick();
        logic e, md, r;
        int s;
        logic [127:0] iv;
        e = en; md = mode; r = out_ready; s = int'(sel); iv = in_v;
        @(posedge clk);
        #1;
        model_step(e, md, s, r, iv);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) in_v[k*8 +: 8] = 8'(8'hA0 + k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = 4'd0; out_ready = 1'b0;
        en2 = 1'b0; en64 = 1'b0; in2 = 2'b10;
        load_ramp();
        for (int k = 0; k < 64; k++) in64[k*32 +: 32] = $urandom;
        model_reset();
        #12;
        asserts++;
        if ({out_data, out_ch, out_last, out_valid} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h ch=%0d last=%b valid=%b, want all 0",
                     out_data, out_ch, out_last, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        load_ramp();
        sel = 4'd5; mode = 1'b0; out_ready = 1'b1; en = 1'b1;
        tick();
        asserts++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL manual_first_edge: got valid=%b, want 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            asserts++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 4'd5 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL manual_beat: got valid=%b data=%h ch=%0d last=%b, want 1 a5 5 0",
                         out_valid, out_data, out_ch, out_last);
            end
        end
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_scan();
        load_ramp();
        mode = 1'b1; out_ready = 1'b1; en = 1'b1;
        tick();
        for (int i = 0; i < 34; i++) begin
            tick();
            asserts++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + (i % 16)) ||
                int'(out_ch) != (i % 16) || out_last !== ((i % 16) == 15)) begin
                errors++;
                $display("FAIL scan_beat%0d: got valid=%b data=%h ch=%0d last=%b, want ch %0d",
                         i, out_valid, out_data, out_ch, out_last, i % 16);
            end
        end
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        logic seen;
        load_ramp();
        mode = 1'b1; out_ready = 1'b1; en = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (out_valid === 1'b1 && out_ch === 4'd7) seen = 1'b1;
        end
        asserts++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_reach_ch7: got ch=%0d after %0d cycles, want 7", out_ch, n);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if (out_valid !== 1'b1 || out_data !== 8'hA7 || out_ch !== 4'd7) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h ch=%0d, want 1 a7 7",
                         i, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        tick();
        asserts++;
        if (out_valid !== 1'b1 || out_data !== 8'hA8 || out_ch !== 4'd8) begin
            errors++;
            $display("FAIL bp_release: got valid=%b data=%h ch=%0d, want 1 a8 8",
                     out_valid, out_data, out_ch);
        end
    endtask

    // Continues from the running scan left by test_backpressure.
    task automatic test_en_drop();
        logic [7:0] held_d;
        logic [3:0] held_c;
        held_d = out_data;
        held_c = out_ch;
        out_ready = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if (out_valid !== 1'b1 || out_data !== held_d || out_ch !== held_c) begin
                errors++;
                $display("FAIL endrop_hold%0d: got valid=%b data=%h ch=%0d, want 1 %h %0d",
                         i, out_valid, out_data, out_ch, held_d, held_c);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            asserts++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL endrop_drain%0d: got valid=%b, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        logic seen;
        load_ramp();
        mode = 1'b1; out_ready = 1'b1; en = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (out_valid === 1'b1 && out_ch === 4'd9) seen = 1'b1;
        end
        asserts++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_reach_ch9: got ch=%0d, want 9", out_ch);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        asserts++;
        if ({out_data, out_ch, out_last, out_valid} !== 14'd0) begin
            errors++;
            $display("FAIL rst_async: got data=%h ch=%0d last=%b valid=%b, want all 0",
                     out_data, out_ch, out_last, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        asserts++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_edge: got valid=%b, want 0", out_valid);
        end
        tick();
        asserts++;
        if (out_valid !== 1'b1 || out_ch !== 4'd0 || out_data !== 8'hA0) begin
            errors++;
            $display("FAIL rst_restart: got valid=%b ch=%0d data=%h, want 1 0 a0",
                     out_valid, out_ch, out_data);
        end
        en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) in_v[k*32 +: 32] = $urandom;
            sel       = 4'($urandom_range(0, 15));
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) en = ~en;
            tick();
            asserts++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b, want %b", i, out_valid, m_valid);
            end else if (m_valid && (out_data !== m_data || int'(out_ch) != m_ch ||
                                     out_last !== m_last)) begin
                errors++;
                $display("FAIL rand_beat@%0d: got data=%h ch=%0d last=%b, want %h %0d %b",
                         i, out_data, out_ch, out_last, m_data, m_ch, m_last);
            end
        end
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_param_sweep();
        en2 = 1'b1; en64 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                asserts++;
                if (valid2 !== 1'b1 || int'(ch2) != (i % 2) || last2 !== (i % 2 == 1) ||
                    d2 !== in2[i % 2]) begin
                    errors++;
                    $display("FAIL n2_beat%0d: got valid=%b ch=%0d last=%b data=%b, want ch %0d",
                             i, valid2, ch2, last2, d2, i % 2);
                end
            end
            asserts++;
            if (valid64 !== 1'b1 || int'(ch64) != (i % 64) || last64 !== (i % 64 == 63) ||
                d64 !== in64[(i % 64)*32 +: 32]) begin
                errors++;
                $display("FAIL n64_beat%0d: got valid=%b ch=%0d last=%b data=%h, want ch %0d",
                         i, valid64, ch64, last64, d64, i % 64);
            end
        end
        en2 = 1'b0; en64 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_backpressure();
        test_en_drop();
        test_reset_mid_scan();
        test_random();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule

// File: doc/mux_nto1_scan.md
MUX_NTO1_SCAN -- requirements
Module: mux_nto1_scan

Interface
REQ-001 The block SHALL have parameter NCH, default 16, number of input channels; power of 2, range 2..64.
REQ-002 The block SHALL have parameter W, default 8, data width per channel, range 1..32.
REQ-003 The block SHALL derive localparam SW = clog2(NCH), the channel-index width.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in, input, NCH*W: flattened channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-007 Port sel, input, SW: channel index used in manual mode.
REQ-008 Port mode, input, 1: 0 = manual, 1 = scan; sampled only when leaving IDLE.
REQ-009 Port en, input, 1: high enables captures.
REQ-010 Port out_data, output, W: registered selected channel data.
REQ-011 Port out_ch, output, SW: index of the channel held in out_data.
REQ-012 Port out_last, output, 1: high on the beat carrying channel NCH-1 in scan mode.
REQ-013 Port out_valid, output, 1: out_data, out_ch and out_last hold an unconsumed beat.
REQ-014 Port out_ready, input, 1: downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, MANUAL and SCAN.
REQ-016 IDLE -> MANUAL SHALL occur when en=1 and mode=0; IDLE -> SCAN SHALL occur when en=1 and mode=1; the transition cycle captures nothing.
REQ-017 MANUAL or SCAN -> IDLE SHALL occur on the first clock edge with en=0; mode changes while active SHALL be ignored.
REQ-018 A capture SHALL occur in MANUAL/SCAN with en=1 when the output register is free (out_valid=0 or out_ready=1).
REQ-019 A manual capture SHALL load out_data=in[sel], out_ch=sel, out_last=0.
REQ-020 A scan capture SHALL load out_data=in[ptr], out_ch=ptr and out_last=(ptr==NCH-1), then set ptr to ptr+1 modulo NCH.
REQ-021 ptr SHALL be set to 0 on every IDLE -> SCAN transition.
REQ-022 Capture-to-out_valid latency SHALL be 1 cycle; full throughput of one beat per cycle SHALL be sustained while out_ready=1.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_ch, out_last and ptr SHALL hold stable.
REQ-024 out_valid SHALL fall after a handshake when no capture occurs in the same cycle; a simultaneous handshake and capture SHALL keep out_valid=1 with the new beat.
REQ-025 When en falls with a beat pending, the beat SHALL remain valid until accepted; no further captures SHALL occur.
REQ-026 Wrap from ptr=NCH-1 to 0 SHALL be seamless: no bubble cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, ptr=0, out_data=0, out_ch=0, out_last=0 and out_valid=0, including mid-transfer, dropping any pending beat.
REQ-028 After rst_n rises, the first capture SHALL occur no earlier than the second rising edge with en=1.

Structure
REQ-029 Shared package mux_pkg SHALL hold the state enum (IDLE, MANUAL, SCAN), the mode encoding constants and the default NCH and W.
REQ-030 Channel selection SHALL be in combinational sub-module mux_sel_comb (parameters NCH and W; ports in, idx, y); mux_nto1_scan owns the FSM, ptr and output register.

Verification
REQ-031 Manual mode: NCH=16, W=8, in[k]=8'hA0+k, sel=5, en=1, out_ready=1 -> out_data=8'hA5, out_ch=5 and out_last=0 from the 2nd cycle after en rises.
REQ-032 Scan mode: same data, out_ready=1 -> 16 consecutive beats 8'hA0..8'hAF, out_last only on 8'hAF, then 8'hA0 again with no gap.
REQ-033 Backpressure: scan, out_ready=0 for 3 cycles at ch 7 -> out_data=8'hA7 held stable; after release the next beat is ch 8 with no channel skipped or repeated.
REQ-034 en drop: en=0 with a beat pending and out_ready=0 -> beat held; IDLE entered; after out_ready=1, out_valid=0 and no new beats.
REQ-035 Reset mid-scan: rst_n=0 at ch 9 -> all outputs 0 asynchronously; a new scan restarts at ch 0.
REQ-036 Parameter sweep: NCH=2, W=1 scan alternates ch 0/1 with out_last on ch 1; NCH=64, W=32 wraps correctly.
